relu_requant: RTL and testbench
===============================

// Module: relu_requant
// PURPOSE
//  Post-accumulation stage feeding maxpooling: takes one signed PE-array accumulator
//  word per cycle, adds the per-channel bias, rounds/shifts, applies optional ReLU and
//  saturates to 8 bits. Output stream (out/out_en) connects directly to maxpooling in/en.
//  Two-stage pipeline with per-channel bias register file and a rotating channel counter.
// PARAMETERS
//  ACC_W   20  accumulator input width (signed)
//  DATA_W  8   output data width
//  CH_NUM  4   channels interleaved in the input stream (bias entries)
//  SH_W    4   width of the shift-amount port
// PORTS
//  clk        in   1              clock, all logic on rising edge
//  reset      in   1              synchronous, active-high reset
//  in         in   ACC_W          signed accumulator word
//  en         in   1              in valid this cycle
//  relu_en    in   1              1: ReLU + unsigned sat [0,255]; 0: signed sat [-128,127]
//  shift      in   SH_W           arithmetic right-shift amount (quasi-static)
//  clr        in   1              sync clear of channel counter (frame start)
//  bias_we    in   1              bias write strobe
//  bias_addr  in   clog2(CH_NUM)  bias entry index
//  bias_data  in   ACC_W          signed bias value
//  out        out  DATA_W         requantised result
//  out_en     out  1              out valid
//  out_ch     out  clog2(CH_NUM)  channel index of out
// BEHAVIOUR
//  - Reset: out=0, out_en=0, out_ch=0, ch_cnt=0, all bias entries=0, both stage valids=0.
//  - Latency exactly 2 cycles: out_en(t+2)=en(t); one result per cycle, no stalls.
//  - ch_cnt increments on each en=1 beat, wraps CH_NUM-1 -> 0; held when en=0.
//  - clr=1: ch_cnt<=0; if en=1 same cycle, that beat uses channel 0 and ch_cnt<=1.
//  - S1: sum = sext(in) + sext(bias[ch_cnt]), ACC_W+1 bits, registered with ch and valid.
//  - S2: if shift>0, r = (sum + (1<<(shift-1))) >>> shift (round half up),
//    else r = sum; ACC_W+2-bit intermediate, no overflow possible.
//  - relu_en=1: out = r<0 ? 0 : min(r,255). relu_en=0: out = clamp(r,-128,127) two's compl.
//  - relu_en/shift are sampled at S2 together with the data they apply to.
//  - Bias write and read of same entry in same cycle: S1 uses OLD value (read-before-write);
//    new value applies from next beat.
//  - out/out_ch hold last value when out_en=0 (no zeroing of data between beats).
//  - Reset mid-stream: in-flight beats discarded; out_en=0 the cycle after reset asserts.
// STRUCTURE
//  - Shared package npu_pkg: ACC_W/DATA_W defaults, UINT8_MAX=255, INT8_MIN/MAX constants.
//  - One sub-module natural: sat_round (combinational round-shift-saturate of S2),
//    reusable by other requant points; bias regfile, ch_cnt and pipeline regs stay in top.
// TESTING
//  - Reset: hold reset 2 cycles with en=1 -> out_en=0, out=0, out_ch=0 throughout.
//  - Basic: bias all 0, shift=0, relu_en=1, in=5,-3,300,255 -> out 5,0,255,255 at t+2.
//  - Bias/round: bias[1]=10, shift=2, in=1 on ch1 -> sum 11, (11+2)>>>2=3 -> out=3, out_ch=1.
//  - Signed mode: relu_en=0, shift=0, in=-200,-5,90 -> out 0x80,0xFB,0x5A.
//  - Channel wrap/clr: 6 beats CH_NUM=4 -> out_ch 0,1,2,3,0,1; clr with beat 3 -> 0,1,2,0,1.
//  - Bubbles + RAW: en toggling 1,0,1 -> out_en mirrors 2 cycles later; bias write to active
//    ch in same cycle -> old bias used, new bias on next beat of that channel.
//  - Chain to maxpooling: feed 60 accumulator words -> maxpooling results match golden model.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU datapath constants: default widths and 8-bit saturation bounds.
package npu_pkg;

    localparam int unsigned NPU_ACC_W  = 20;
    localparam int unsigned NPU_DATA_W = 8;
    localparam int unsigned NPU_CH_NUM = 4;
    localparam int unsigned NPU_SH_W   = 4;

    localparam int UINT8_MAX = 255;
    localparam int INT8_MIN  = -128;
    localparam int INT8_MAX  = 127;

endpackage

// File: rtl/sat_round.sv
// Combinational requantiser: round-half-up arithmetic right shift, then ReLU/unsigned
// or signed saturation down to DATA_W bits.
module sat_round
    import npu_pkg::*;
#(
    parameter int unsigned ACC_W  = NPU_ACC_W,
    parameter int unsigned DATA_W = NPU_DATA_W,
    parameter int unsigned SH_W   = NPU_SH_W
) (
    input  logic signed [ACC_W:0]  sum_i,
    input  logic [SH_W-1:0]        shift_i,
    input  logic                   relu_en_i,
    output logic [DATA_W-1:0]      data_o
);

    localparam int unsigned RW = ACC_W + 2;
    localparam logic signed [RW-1:0] UMax = RW'((1 << DATA_W) - 1);
    localparam logic signed [RW-1:0] SMax = RW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [RW-1:0] SMin = RW'(-(1 << (DATA_W - 1)));

    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] half;
    logic signed [RW-1:0] r;

    always_comb begin
        ext  = {sum_i[ACC_W], sum_i};
        half = '0;
        r    = ext;
        if (shift_i != '0) begin
            half = RW'(1) << (shift_i - 1'b1);
            r    = (ext + half) >>> shift_i;
        end

        data_o = r[DATA_W-1:0];
        if (relu_en_i) begin
            if (r[RW-1]) begin
                data_o = '0;
            end else if (r > UMax) begin
                data_o = '1;
            end
        end else begin
            if (r < SMin) begin
                data_o = {1'b1, {(DATA_W - 1){1'b0}}};
            end else if (r > SMax) begin
                data_o = {1'b0, {(DATA_W - 1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/relu_requant.sv
// Post-accumulation stage: per-channel bias add (S1), round/shift/ReLU/saturate (S2),
// with a rotating channel counter over the interleaved input stream.
module relu_requant
    import npu_pkg::*;
#(
    parameter int unsigned ACC_W  = NPU_ACC_W,
    parameter int unsigned DATA_W = NPU_DATA_W,
    parameter int unsigned CH_NUM = NPU_CH_NUM,
    parameter int unsigned SH_W   = NPU_SH_W,
    parameter int unsigned CH_W   = $clog2(CH_NUM)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [ACC_W-1:0] in,
    input  logic                     en,
    input  logic                     relu_en,
    input  logic [SH_W-1:0]          shift,
    input  logic                     clr,
    input  logic                     bias_we,
    input  logic [CH_W-1:0]          bias_addr,
    input  logic signed [ACC_W-1:0] bias_data,
    output logic [DATA_W-1:0]        out,
    output logic                     out_en,
    output logic [CH_W-1:0]          out_ch
);

    logic [ACC_W-1:0]      bias_q [CH_NUM];
    logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d, ch_cur;
    logic signed [ACC_W:0] sum_d, s1_sum_q;
    logic [CH_W-1:0]       s1_ch_q;
    logic                  s1_vld_q;
    logic [DATA_W-1:0]     sat_data, out_q;
    logic [CH_W-1:0]       out_ch_q;
    logic                  out_en_q;

    // clr redirects the current beat to channel 0; bias is read before any same-cycle write.
    always_comb begin
        ch_cur   = clr ? '0 : ch_cnt_q;
        ch_cnt_d = ch_cur;
        if (en) begin
            ch_cnt_d = (ch_cur == CH_W'(CH_NUM - 1)) ? '0 : ch_cur + 1'b1;
        end
        sum_d = {in[ACC_W-1], in} + {bias_q[ch_cur][ACC_W-1], bias_q[ch_cur]};
    end

    sat_round #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .SH_W   (SH_W)
    ) u_sat_round (
        .sum_i     (s1_sum_q),
        .shift_i   (shift),
        .relu_en_i (relu_en),
        .data_o    (sat_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                bias_q[i] <= '0;
            end
            ch_cnt_q <= '0;
            s1_sum_q <= '0;
            s1_ch_q  <= '0;
            s1_vld_q <= 1'b0;
            out_q    <= '0;
            out_ch_q <= '0;
            out_en_q <= 1'b0;
        end else begin
            ch_cnt_q <= ch_cnt_d;
            if (bias_we) begin
                bias_q[bias_addr] <= bias_data;
            end
            s1_vld_q <= en;
            if (en) begin
                s1_sum_q <= sum_d;
                s1_ch_q  <= ch_cur;
            end
            out_en_q <= s1_vld_q;
            if (s1_vld_q) begin
                out_q    <= sat_data;
                out_ch_q <= s1_ch_q;
            end
        end
    end

    assign out    = out_q;
    assign out_en = out_en_q;
    assign out_ch = out_ch_q;

endmodule

// File: tb/tb_relu_requant.sv
// Directed bench for relu_requant: reset, ReLU/signed saturation, bias rounding, channel
// wrap/clr, bubbles with bias read-before-write, mid-stream reset and a pooled stream.
module tb_relu_requant;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [19:0] in_s = '0;
    logic               en = 1'b0;
    logic               relu_en = 1'b1;
    logic [3:0]         shift = '0;
    logic               clr = 1'b0;
    logic               bias_we = 1'b0;
    logic [1:0]         bias_addr = '0;
    logic signed [19:0] bias_data = '0;
    logic [7:0]         out_s;
    logic               out_en_s;
    logic [1:0]         out_ch_s;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    relu_requant u_dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_s),
        .en        (en),
        .relu_en   (relu_en),
        .shift     (shift),
        .clr       (clr),
        .bias_we   (bias_we),
        .bias_addr (bias_addr),
        .bias_data (bias_data),
        .out       (out_s),
        .out_en    (out_en_s),
        .out_ch    (out_ch_s)
    );

    // Drive one cycle of stream inputs, returning at the next falling edge.
    task automatic cyc(input bit e, input int d, input bit c);
        en   = e;
        in_s = 20'(d);
        clr  = c;
        @(negedge clk);
        bias_we = 1'b0;
    endtask

    function automatic logic [7:0] model(input int acc, input int b, input int sh, input bit relu);
        int s;
        s = acc + b;
        if (sh > 0) s = (s + (1 << (sh - 1))) >>> sh;
        if (relu) begin
            if (s < 0) return 8'd0;
            if (s > 255) return 8'd255;
        end else begin
            if (s < -128) return 8'h80;
            if (s > 127) return 8'h7f;
        end
        return 8'(s);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b1;
        in_s  = 20'sd5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_en_s !== 1'b0) begin
                n_fail++; $display("FAIL reset_out_en c%0d: got %b want 0", i, out_en_s);
            end
            n_cmp++;
            if (out_s !== 8'd0) begin
                n_fail++; $display("FAIL reset_out c%0d: got %0h want 0", i, out_s);
            end
            n_cmp++;
            if (out_ch_s !== 2'd0) begin
                n_fail++; $display("FAIL reset_out_ch c%0d: got %0d want 0", i, out_ch_s);
            end
        end
        reset = 1'b0;
        cyc(0, 0, 0);
    endtask

    task automatic test_basic();
        int         vin[4] = '{5, -3, 300, 255};
        logic [7:0] eo[4]  = '{8'd5, 8'd0, 8'd255, 8'd255};
        relu_en = 1'b1;
        shift   = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) begin
                n_cmp++;
                if (out_en_s !== 1'b1 || out_s !== eo[i-2] || out_ch_s !== 2'(i - 2)) begin
                    n_fail++;
                    $display("FAIL basic b%0d: got en=%b out=%0d ch=%0d want en=1 out=%0d ch=%0d",
                             i - 2, out_en_s, out_s, out_ch_s, eo[i-2], i - 2);
                end
            end
            if (i < 4) cyc(1, vin[i], 0);
            else cyc(0, 0, 0);
        end
    endtask

    task automatic test_bias_round();
        int         vin[4] = '{0, 1, -7, 6};
        logic [7:0] eo[4]  = '{8'd0, 8'd3, 8'hFE, 8'd2};
        bias_we = 1'b1; bias_addr = 2'd1; bias_data = 20'sd10;
        cyc(0, 0, 1);
        relu_en = 1'b0;
        shift   = 4'd2;
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) begin
                n_cmp++;
                if (out_s !== eo[i-2] || out_ch_s !== 2'(i - 2)) begin
                    n_fail++;
                    $display("FAIL bias_round b%0d: got out=%0h ch=%0d want out=%0h ch=%0d",
                             i - 2, out_s, out_ch_s, eo[i-2], i - 2);
                end
            end
            if (i < 4) cyc(1, vin[i], 0);
            else cyc(0, 0, 0);
        end
        bias_we = 1'b1; bias_addr = 2'd1; bias_data = '0;
        cyc(0, 0, 0);
    endtask

    task automatic test_signed();
        int         vin[3] = '{-200, -5, 90};
        logic [7:0] eo[3]  = '{8'h80, 8'hFB, 8'h5A};
        relu_en = 1'b0;
        shift   = 4'd0;
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                n_cmp++;
                if (out_s !== eo[i-2] || out_ch_s !== 2'(i - 2)) begin
                    n_fail++;
                    $display("FAIL signed b%0d: got out=%0h ch=%0d want out=%0h ch=%0d",
                             i - 2, out_s, out_ch_s, eo[i-2], i - 2);
                end
            end
            if (i < 3) cyc(1, vin[i], i == 0);
            else cyc(0, 0, 0);
        end
    endtask

    task automatic test_wrap_clr();
        logic [1:0] ech[11] = '{0, 1, 2, 3, 0, 1, 0, 1, 2, 0, 1};
        relu_en = 1'b1;
        shift   = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (i >= 2) begin
                n_cmp++;
                if (out_ch_s !== ech[i-2] || out_s !== 8'(i - 1)) begin
                    n_fail++;
                    $display("FAIL wrap_clr b%0d: got ch=%0d out=%0d want ch=%0d out=%0d",
                             i - 2, out_ch_s, out_s, ech[i-2], i - 1);
                end
            end
            if (i < 11) cyc(1, i + 1, i == 0 || i == 6 || i == 9);
            else cyc(0, 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        bit         ven[6] = '{1, 0, 1, 1, 1, 1};
        int         vin[6] = '{1, 0, 2, 3, 4, 1};
        logic [7:0] eo[6]  = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd101};
        logic [1:0] ech[6] = '{0, 0, 1, 2, 3, 0};
        relu_en = 1'b1;
        shift   = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (i >= 2) begin
                logic eexp;
                eexp = (i < 8) ? ven[i-2] : 1'b0;
                n_cmp++;
                if (out_en_s !== eexp) begin
                    n_fail++;
                    $display("FAIL bubble_en c%0d: got %b want %b", i - 2, out_en_s, eexp);
                end
                if (i < 8) begin
                    n_cmp++;
                    if (out_s !== eo[i-2] || out_ch_s !== ech[i-2]) begin
                        n_fail++;
                        $display("FAIL raw_data c%0d: got out=%0d ch=%0d want out=%0d ch=%0d",
                                 i - 2, out_s, out_ch_s, eo[i-2], ech[i-2]);
                    end
                end
            end
            if (i == 0) begin
                bias_we = 1'b1; bias_addr = 2'd0; bias_data = 20'sd100;
            end
            if (i < 6) cyc(ven[i], vin[i], i == 0);
            else cyc(0, 0, 0);
        end
    endtask

    task automatic test_reset_midstream();
        cyc(1, 50, 1);
        reset = 1'b1;
        cyc(0, 0, 0);
        n_cmp++;
        if (out_en_s !== 1'b0 || out_s !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_flush: got en=%b out=%0d want en=0 out=0", out_en_s, out_s);
        end
        reset = 1'b0;
        cyc(0, 0, 0);
        n_cmp++;
        if (out_en_s !== 1'b0) begin
            n_fail++; $display("FAIL midreset_drop: got en=%b want 0", out_en_s);
        end
    endtask

    task automatic test_chain();
        int         vb[4] = '{-40, 16, 0, 200};
        logic [7:0] exp_q[60];
        logic [7:0] dmax[4];
        logic [7:0] mmax[4];
        int         v;
        for (int c = 0; c < 4; c++) begin
            bias_we = 1'b1; bias_addr = 2'(c); bias_data = 20'(vb[c]);
            cyc(0, 0, 0);
            dmax[c] = '0;
            mmax[c] = '0;
        end
        relu_en = 1'b1;
        shift   = 4'd3;
        for (int i = 0; i < 62; i++) begin
            if (i >= 2) begin
                n_cmp++;
                if (out_en_s !== 1'b1 || out_s !== exp_q[i-2] || out_ch_s !== 2'((i - 2) % 4)) begin
                    n_fail++;
                    $display("FAIL chain b%0d: got en=%b out=%0d ch=%0d want en=1 out=%0d ch=%0d",
                             i - 2, out_en_s, out_s, out_ch_s, exp_q[i-2], (i - 2) % 4);
                end
                if (out_s > dmax[out_ch_s]) dmax[out_ch_s] = out_s;
            end
            if (i < 60) begin
                v = ((i * 7919) % 4001) - 2000 + ((i % 4 == 3) ? 3000 : 0);
                exp_q[i] = model(v, vb[i % 4], 3, 1'b1);
                if (exp_q[i] > mmax[i % 4]) mmax[i % 4] = exp_q[i];
                cyc(1, v, i == 0);
            end else begin
                cyc(0, 0, 0);
            end
        end
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (dmax[c] !== mmax[c]) begin
                n_fail++;
                $display("FAIL pool_max ch%0d: got %0d want %0d", c, dmax[c], mmax[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bias_round();
        test_signed();
        test_wrap_clr();
        test_back_to_back();
        test_reset_midstream();
        test_chain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
